// File: rtl/mas_bist.sv
// mas_bist: three-stage self-test sequencer for the MAS_2input block.
// Streams ROM patterns into the MAS and tallies per-stage mismatches.

module mas_bist #(
  parameter int NUM_PAT = 200,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              pat_bank,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [23:0]       pat_data,
  output logic [4:0]        din1,
  output logic [4:0]        din2,
  output logic [4:0]        q,
  output logic [1:0]        sel,
  input  logic [4:0]        tdout,
  input  logic [1:0]        comparater,
  input  logic [3:0]        dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        stage,
  output logic [7:0]        err_cnt,
  output logic [2:0]        fail_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_PAT - 1);

  state_t            state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        din1_q, din1_d;
  logic [3:0]        din2_q, din2_d;
  logic [3:0]        qm_q, qm_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        gold_q, gold_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        stage_q, stage_d;
  logic [7:0]        err_q, err_d;
  logic [2:0]        flags_q, flags_d;

  logic last;
  logic miss;
  logic stage_err;
  logic launch;
  logic unused_pat;

  assign last      = (addr_q == LAST_ADDR);
  assign stage_err = (err_q != 8'd0);
  assign unused_pat = ^pat_data[11:10];

  assign launch = start &&
    ((state_q == S_IDLE) || (state_q == S_DONE));

  // Each stage looks at a different MAS output against its own gold slice.
  assign miss =
    (stage_q == 2'd1) ? (tdout != gold_q[4:0]) :
    (stage_q == 2'd2) ? (comparater != gold_q[1:0]) :
                        (dout != gold_q[7:4]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      din1_q  <= 4'd0;
      din2_q  <= 4'd0;
      qm_q    <= 4'd0;
      sel_q   <= 2'd0;
      gold_q  <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      stage_q <= 2'd0;
      err_q   <= 8'd0;
      flags_q <= 3'd0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      qm_q    <= qm_d;
      sel_q   <= sel_d;
      gold_q  <= gold_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      stage_q <= stage_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        state_d = last ? S_NEXT : S_FETCH;
      end
      S_NEXT: begin
        if ((stage_q == 2'd3) ||
            ((stage_q == 2'd1) && stage_err))
          state_d = S_DONE;
        else
          state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bank_d  = bank_q;
    addr_d  = addr_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
    qm_d    = qm_q;
    sel_d   = sel_q;
    gold_d  = gold_q;
    done_d  = done_q;
    pass_d  = pass_q;
    stage_d = stage_q;
    err_d   = err_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE,
      S_DONE: begin
        if (launch) begin
          err_d   = 8'd0;
          flags_d = 3'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          stage_d = 2'd1;
          bank_d  = 1'b0;
          addr_d  = '0;
        end
      end
      S_LOAD: begin
        if (bank_q) begin
          din1_d = pat_data[23:20];
          din2_d = pat_data[19:16];
          qm_d   = pat_data[15:12];
        end else begin
          din1_d = pat_data[19:16];
          din2_d = pat_data[15:12];
          qm_d   = 4'd0;
        end
        sel_d  = pat_data[9:8];
        gold_d = pat_data[7:0];
      end
      S_CHECK: begin
        if (miss && (err_q != 8'hFF))
          err_d = err_q + 8'd1;
        if (!last)
          addr_d = addr_q + ADDR_W'(1);
      end
      S_NEXT: begin
        unique case (stage_q)
          2'd1:    flags_d[0] = stage_err;
          2'd2:    flags_d[1] = stage_err;
          default: flags_d[2] = stage_err;
        endcase
        if ((stage_q == 2'd1) && !stage_err) begin
          stage_d = 2'd2;
          bank_d  = 1'b1;
          addr_d  = '0;
          err_d   = 8'd0;
        end else if (stage_q == 2'd2) begin
          stage_d = 2'd3;
          addr_d  = '0;
          err_d   = 8'd0;
        end else begin
          done_d = 1'b1;
          pass_d = ~|flags_d;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == S_FETCH) ||
                (state_q == S_LOAD)  ||
                (state_q == S_CHECK) ||
                (state_q == S_NEXT);

  assign pat_bank   = bank_q;
  assign pat_addr   = addr_q;
  assign din1       = {1'b0, din1_q};
  assign din2       = {1'b0, din2_q};
  assign q          = {1'b0, qm_q};
  assign sel        = sel_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign stage      = stage_q;
  assign err_cnt    = err_q;
  assign fail_flags = flags_q;

endmodule

// File: tb/tb_mas_bist.sv
// tb_mas_bist: runs mas_bist against a behavioural MAS and pattern ROM.
// Scenario table, hand sequences and randomized gold corruption.

module tb_mas_bist;

  localparam int NP = 200;
  localparam int NS = 256;

  typedef struct {
    int         alu_bad;
    int         cmp_a;
    int         cmp_b;
    int         dout_a;
    int         dout_b;
    int         cyc;
    int         stg;
    int         err;
    logic [2:0] fl;
    logic       ps;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a;
  logic start_b;
  logic bank_seen;

  logic [23:0] rom_alu [256];
  logic [23:0] rom_mas [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_bank, a_busy, a_done, a_pass;
  logic [7:0]  a_addr, a_err;
  logic [23:0] pd_a;
  logic [4:0]  a_din1, a_din2, a_q, a_tdout;
  logic [1:0]  a_sel, a_cmp, a_stage;
  logic [3:0]  a_dout;
  logic [2:0]  a_fl;
  logic [10:0] ma;

  logic        b_bank, b_busy, b_done, b_pass;
  logic [7:0]  b_addr, b_err;
  logic [23:0] pd_b;
  logic [4:0]  b_din1, b_din2, b_q, b_tdout;
  logic [1:0]  b_sel, b_cmp, b_stage;
  logic [3:0]  b_dout;
  logic [2:0]  b_fl;
  logic [10:0] mb;

  // Behavioural MAS: {tdout, comparater, dout}
  function automatic logic [10:0] mas_fn(
    input logic [4:0] x, input logic [4:0] y,
    input logic [4:0] m, input logic [1:0] s);
    logic [4:0] t;
    logic [1:0] c;
    logic [4:0] r;
    t = (s == 2'b11) ? x - y : x + y;
    if (t == m)     c = 2'b10;
    else if (t > m) c = 2'b01;
    else            c = 2'b00;
    r = (c != 2'b00) ? t - m : t;
    return {t, c, r[3:0]};
  endfunction

  mas_bist #(.NUM_PAT(NP), .ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start_a),
    .pat_bank(a_bank), .pat_addr(a_addr),
    .pat_data(pd_a),
    .din1(a_din1), .din2(a_din2), .q(a_q),
    .sel(a_sel), .tdout(a_tdout),
    .comparater(a_cmp), .dout(a_dout),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .stage(a_stage), .err_cnt(a_err),
    .fail_flags(a_fl)
  );

  mas_bist #(.NUM_PAT(NS), .ADDR_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start_b),
    .pat_bank(b_bank), .pat_addr(b_addr),
    .pat_data(pd_b),
    .din1(b_din1), .din2(b_din2), .q(b_q),
    .sel(b_sel), .tdout(b_tdout),
    .comparater(b_cmp), .dout(b_dout),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .stage(b_stage), .err_cnt(b_err),
    .fail_flags(b_fl)
  );

  always @(posedge clk)
    pd_a <= a_bank ? rom_mas[a_addr] : rom_alu[a_addr];
  always @(posedge clk)
    pd_b <= b_bank ? rom_mas[b_addr] : rom_alu[b_addr];

  assign ma      = mas_fn(a_din1, a_din2, a_q, a_sel);
  assign a_tdout = ma[10:6];
  assign a_cmp   = ma[5:4];
  assign a_dout  = ma[3:0];

  assign mb      = mas_fn(b_din1, b_din2, b_q, b_sel);
  assign b_tdout = mb[10:6];
  assign b_cmp   = mb[5:4];
  assign b_dout  = mb[3:0] | 4'hF;

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
        nm, act, exp);
    end
  endtask

  task automatic fill_rom();
    logic [23:0] r;
    logic [3:0]  x, y, m;
    logic [1:0]  s;
    logic [10:0] o;
    for (int i = 0; i < 256; i++) begin
      r = 24'($urandom);
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      o = mas_fn({1'b0, x}, {1'b0, y}, 5'd0, s);
      rom_alu[i] = {r[23:20], x, y, r[11:10], s,
                    r[7:5], o[10:6]};
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      m = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      o = mas_fn({1'b0, x}, {1'b0, y}, {1'b0, m}, s);
      rom_mas[i] = {x, y, m, r[11:10], s, o[3:0],
                    r[3:2], o[5:4]};
    end
  endtask

  // Expected run outcome from ROM contents and the stage rules.
  task automatic model(input int n, input bit tie,
    output int e_cyc, output int e_stg,
    output int e_err, output logic [2:0] e_fl,
    output logic e_pass);
    int c1, c2, c3;
    logic [10:0] o;
    logic [3:0] dv;
    c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < n; i++) begin
      o = mas_fn({1'b0, rom_alu[i][19:16]},
        {1'b0, rom_alu[i][15:12]}, 5'd0,
        rom_alu[i][9:8]);
      if (o[10:6] != rom_alu[i][4:0]) c1++;
      o = mas_fn({1'b0, rom_mas[i][23:20]},
        {1'b0, rom_mas[i][19:16]},
        {1'b0, rom_mas[i][15:12]}, rom_mas[i][9:8]);
      dv = tie ? 4'hF : o[3:0];
      if (o[5:4] != rom_mas[i][1:0]) c2++;
      if (dv != rom_mas[i][7:4]) c3++;
    end
    if (c1 > 0) begin
      e_cyc = 3 * n + 1; e_stg = 1;
      e_err = (c1 > 255) ? 255 : c1;
      e_fl = 3'b001; e_pass = 1'b0;
    end else begin
      e_cyc = 9 * n + 3; e_stg = 3;
      e_err = (c3 > 255) ? 255 : c3;
      e_fl = {c3 > 0, c2 > 0, 1'b0};
      e_pass = (c2 == 0) && (c3 == 0);
    end
  endtask

  task automatic run_a(output int cyc);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc = 0;
    bank_seen = 1'b0;
    while (!a_done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (a_bank) bank_seen = 1'b1;
    end
  endtask

  task automatic check_run(input string tg,
    input int cyc, input int e_cyc, input int e_stg,
    input int e_err, input logic [2:0] e_fl,
    input logic e_pass);
    chk({tg, " cycles"}, cyc, e_cyc);
    chk({tg, " done"}, a_done, 1);
    chk({tg, " stage"}, a_stage, e_stg);
    chk({tg, " err_cnt"}, a_err, e_err);
    chk({tg, " fail_flags"}, a_fl, e_fl);
    chk({tg, " pass"}, a_pass, e_pass);
    chk({tg, " busy"}, a_busy, 0);
  endtask

  task automatic zero_a(input string tg);
    chk({tg, " ctl"},
      {a_busy, a_done, a_pass, a_stage, a_fl, a_bank}, 0);
    chk({tg, " cnt/addr"}, {a_err, a_addr}, 0);
    chk({tg, " drive"},
      {a_din1, a_din2, a_q, a_sel}, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t vecs [6];
    int cyc, n, i;
    int e_cyc, e_stg, e_err;
    logic [2:0] e_fl;
    logic e_pass;

    vecs[0] = '{-1, -1, -1, -1, -1, 1803, 3, 0, 3'b000, 1'b1};
    vecs[1] = '{5, -1, -1, -1, -1, 601, 1, 1, 3'b001, 1'b0};
    vecs[2] = '{-1, 0, 199, -1, -1, 1803, 3, 0, 3'b010, 1'b0};
    vecs[3] = '{-1, -1, -1, 17, 42, 1803, 3, 2, 3'b100, 1'b0};
    vecs[4] = '{-1, 7, -1, 199, -1, 1803, 3, 1, 3'b110, 1'b0};
    vecs[5] = '{199, 3, -1, -1, -1, 601, 1, 1, 3'b001, 1'b0};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    fill_rom();
    repeat (3) @(posedge clk);
    #1;
    zero_a("reset");
    chk("reset sat",
      {b_busy, b_done, b_pass, b_stage, b_err, b_fl}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      v = vecs[t];
      fill_rom();
      if (v.alu_bad >= 0)
        rom_alu[v.alu_bad] = 24'h09400E;
      if (v.cmp_a >= 0)
        rom_mas[v.cmp_a][1:0] = rom_mas[v.cmp_a][1:0] ^ 2'b11;
      if (v.cmp_b >= 0)
        rom_mas[v.cmp_b][1:0] = rom_mas[v.cmp_b][1:0] ^ 2'b11;
      if (v.dout_a >= 0)
        rom_mas[v.dout_a][7:4] = rom_mas[v.dout_a][7:4] ^ 4'hF;
      if (v.dout_b >= 0)
        rom_mas[v.dout_b][7:4] = rom_mas[v.dout_b][7:4] ^ 4'hF;
      run_a(cyc);
      check_run($sformatf("vec%0d", t), cyc, v.cyc,
        v.stg, v.err, v.fl, v.ps);
      if (v.alu_bad >= 0)
        chk($sformatf("vec%0d bank stays 0", t),
          bank_seen, 0);
    end

    // Drive sequence and per-pattern spacing
    fill_rom();
    rom_mas[0] = 24'h3A5300;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("fetch state", {a_busy, a_done, a_stage, a_bank},
      {1'b1, 1'b0, 2'd1, 1'b0});
    chk("fetch addr", a_addr, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("alu din1", a_din1, {1'b0, rom_alu[0][19:16]});
    chk("alu din2", a_din2, {1'b0, rom_alu[0][15:12]});
    chk("alu q", a_q, 0);
    chk("alu sel", a_sel, rom_alu[0][9:8]);
    n = 0;
    while (a_stage != 2'd2 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach stage2", a_stage, 2);
    chk("stage2 bank", a_bank, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mas din1", a_din1, 3);
    chk("mas din2", a_din2, 10);
    chk("mas q", a_q, 5);
    chk("mas sel", a_sel, 3);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      i = a_addr;
      while (a_addr == 8'(i) && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("addr spacing %0d", k), n,
        (k == 0) ? 1 : 3);
    end
    n = 0;
    while (!a_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drive run done", a_done, 1);
    chk("drive run flags", a_fl, 3'b110);
    chk("drive run pass", a_pass, 0);

    // Ignored start at cycle 50, reset at cycle 700
    fill_rom();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n = 0;
    while (n < 49) begin
      @(posedge clk);
      #1;
      n++;
    end
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n++;
    @(posedge clk);
    #1;
    n++;
    chk("busy start ignored", a_busy, 1);
    chk("addr start ignored", a_addr, 17);
    while (n < 699) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    zero_a("mid-run rst");
    start_a = 1'b1;
    @(posedge clk);
    #1;
    chk("rst beats start", {a_busy, a_done}, 0);
    rst = 1'b0;
    start_a = 1'b0;
    run_a(cyc);
    check_run("rerun", cyc, 1803, 3, 0, 3'b000, 1'b1);

    // Randomized gold corruption vs model
    for (int k = 0; k < 5; k++) begin
      fill_rom();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          i = $urandom_range(0, NP - 1);
          rom_alu[i][4:0] = rom_alu[i][4:0] ^
            5'($urandom_range(1, 31));
        end
      end
      repeat ($urandom_range(0, 3)) begin
        i = $urandom_range(0, NP - 1);
        rom_mas[i][1:0] = rom_mas[i][1:0] ^
          2'($urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 3)) begin
        i = $urandom_range(0, NP - 1);
        rom_mas[i][7:4] = rom_mas[i][7:4] ^
          4'($urandom_range(1, 15));
      end
      model(NP, 1'b0, e_cyc, e_stg, e_err, e_fl, e_pass);
      run_a(cyc);
      check_run($sformatf("rand%0d", k), cyc, e_cyc,
        e_stg, e_err, e_fl, e_pass);
    end

    // Saturation: dout tied high, every stage-3 gold zero
    fill_rom();
    for (int k = 0; k < 256; k++)
      rom_mas[k][7:4] = 4'h0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("sat cycles", cyc, 2307);
    chk("sat stage", b_stage, 3);
    chk("sat err_cnt", b_err, 255);
    chk("sat fail_flags", b_fl, 3'b100);
    chk("sat pass", b_pass, 0);

    $display("[TB] %0d tests run, %0d failed",
      n_tests, n_fail);
    $finish;
  end

endmodule
